// File: rtl/axis_step_scheduler.sv
// Trigger sequencer for the axis_stepper gate: arms the gate for exactly one
// beat per step, with a programmable idle delay and step count per run.
module axis_step_scheduler #(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNTR_WIDTH-1:0] cfg_period,
  input  logic [CNTR_WIDTH-1:0] cfg_steps,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mon_tvalid,
  output logic                  trg_flag,
  output logic                  busy,
  output logic                  done,
  output logic [CNTR_WIDTH-1:0] step_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;

  localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [CNTR_WIDTH-1:0] delay_cnt;
  logic [CNTR_WIDTH-1:0] period_q;
  logic [CNTR_WIDTH-1:0] steps_q;
  logic [CNTR_WIDTH-1:0] count_next;
  logic                  last_step;

  // N == 0 selects continuous mode, so it never matches as a final step.
  assign count_next = step_count + ONE;
  assign last_step  = (steps_q != '0) && (count_next == steps_q);

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start && !stop) state_next = DELAY;
      DELAY: begin
        if (stop)                  state_next = IDLE;
        else if (delay_cnt == '0)  state_next = ARMED;
      end
      ARMED: begin
        if (stop)                  state_next = IDLE;
        else if (mon_tvalid)       state_next = last_step ? IDLE : DELAY;
      end
      default:                     state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      trg_flag   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_count <= '0;
      delay_cnt  <= '0;
      period_q   <= '0;
      steps_q    <= '0;
    end else begin
      state    <= state_next;
      // Outputs are flopped from the next state so they are glitch-free decodes.
      trg_flag <= (state_next == ARMED);
      busy     <= (state_next != IDLE);
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            period_q   <= cfg_period;
            steps_q    <= cfg_steps;
            step_count <= '0;
            delay_cnt  <= cfg_period;
          end
        end
        DELAY: begin
          if (!stop && delay_cnt != '0) delay_cnt <= delay_cnt - ONE;
        end
        ARMED: begin
          // A beat accepted on the same edge as stop still counts.
          if (mon_tvalid) begin
            step_count <= count_next;
            if (!stop) begin
              if (last_step) done      <= 1'b1;
              else           delay_cnt <= period_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_step_scheduler.sv
// Directed bench for axis_step_scheduler: per-cycle output patterns are
// captured as bit vectors and compared against hand-derived timelines.
module tb_axis_step_scheduler;

  logic        aclk;
  logic        areset;
  logic [31:0] cfg_period;
  logic [31:0] cfg_steps;
  logic        start;
  logic        stop;
  logic        mon_tvalid;
  logic        trg_flag;
  logic        busy;
  logic        done;
  logic [31:0] step_count;

  logic [3:0]  w_period;
  logic [3:0]  w_steps;
  logic        w_start;
  logic        w_stop;
  logic        w_tvalid;
  logic        w_trg;
  logic        w_busy;
  logic        w_done;
  logic [3:0]  w_count;

  int checks;
  int failures;

  logic [31:0] trg_v;
  logic [31:0] busy_v;
  logic [31:0] done_v;
  logic [31:0] xfer_v;

  axis_step_scheduler #(.CNTR_WIDTH(32)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cfg_period (cfg_period),
    .cfg_steps  (cfg_steps),
    .start      (start),
    .stop       (stop),
    .mon_tvalid (mon_tvalid),
    .trg_flag   (trg_flag),
    .busy       (busy),
    .done       (done),
    .step_count (step_count)
  );

  axis_step_scheduler #(.CNTR_WIDTH(4)) dut_w4 (
    .aclk       (aclk),
    .areset     (areset),
    .cfg_period (w_period),
    .cfg_steps  (w_steps),
    .start      (w_start),
    .stop       (w_stop),
    .mon_tvalid (w_tvalid),
    .trg_flag   (w_trg),
    .busy       (w_busy),
    .done       (w_done),
    .step_count (w_count)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_v();
    trg_v  = '0;
    busy_v = '0;
    done_v = '0;
    xfer_v = '0;
  endtask

  task automatic sample(input int c);
    trg_v[c]  = trg_flag;
    busy_v[c] = busy;
    done_v[c] = done;
    xfer_v[c] = trg_flag & mon_tvalid;
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; stop = 1'b0; mon_tvalid = 1'b0;
    cfg_period = '0; cfg_steps = '0;
    w_start = 1'b0; w_stop = 1'b0; w_tvalid = 1'b0; w_period = '0; w_steps = '0;
    tick();
    tick();
    checks++; if (trg_flag !== 1'b0) begin failures++; $display("FAIL reset_trg got=%b exp=0", trg_flag); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (step_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", step_count); end
    checks++; if ({w_trg, w_busy, w_done, w_count} !== 7'd0) begin failures++; $display("FAIL reset_w4 got=%b exp=0", {w_trg, w_busy, w_done, w_count}); end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    clear_v();
    cfg_period = 32'd3; cfg_steps = 32'd2; mon_tvalid = 1'b1; start = 1'b1;
    sample(0);
    for (int c = 1; c < 16; c++) begin
      tick();
      start = 1'b0;
      sample(c);
    end
    checks++; if (trg_v !== 32'h0000_0420) begin failures++; $display("FAIL normal_trg got=%h exp=%h", trg_v, 32'h0000_0420); end
    checks++; if (busy_v !== 32'h0000_07FE) begin failures++; $display("FAIL normal_busy got=%h exp=%h", busy_v, 32'h0000_07FE); end
    checks++; if (done_v !== 32'h0000_0800) begin failures++; $display("FAIL normal_done got=%h exp=%h", done_v, 32'h0000_0800); end
    checks++; if (step_count !== 32'd2) begin failures++; $display("FAIL normal_count got=%0d exp=2", step_count); end
  endtask

  task automatic test_stall();
    clear_v();
    cfg_period = 32'd0; cfg_steps = 32'd3; mon_tvalid = 1'b0; start = 1'b1;
    sample(0);
    for (int c = 1; c < 20; c++) begin
      tick();
      start = 1'b0;
      mon_tvalid = (c >= 10);
      sample(c);
    end
    mon_tvalid = 1'b0;
    checks++; if (trg_v !== 32'h0000_57FC) begin failures++; $display("FAIL stall_trg got=%h exp=%h", trg_v, 32'h0000_57FC); end
    checks++; if (xfer_v !== 32'h0000_5400) begin failures++; $display("FAIL stall_xfer got=%h exp=%h", xfer_v, 32'h0000_5400); end
    checks++; if (done_v !== 32'h0000_8000) begin failures++; $display("FAIL stall_done got=%h exp=%h", done_v, 32'h0000_8000); end
    checks++; if (busy_v !== 32'h0000_7FFE) begin failures++; $display("FAIL stall_busy got=%h exp=%h", busy_v, 32'h0000_7FFE); end
    checks++; if (step_count !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", step_count); end
  endtask

  task automatic test_continuous_stop();
    clear_v();
    cfg_period = 32'd1; cfg_steps = 32'd0; mon_tvalid = 1'b1; start = 1'b1;
    sample(0);
    for (int c = 1; c < 17; c++) begin
      tick();
      start = 1'b0;
      stop = (c == 12);
      sample(c);
    end
    stop = 1'b0;
    checks++; if (trg_v !== 32'h0000_1248) begin failures++; $display("FAIL cont_trg got=%h exp=%h", trg_v, 32'h0000_1248); end
    checks++; if (busy_v !== 32'h0000_1FFE) begin failures++; $display("FAIL cont_busy got=%h exp=%h", busy_v, 32'h0000_1FFE); end
    checks++; if (done_v !== 32'h0) begin failures++; $display("FAIL cont_done got=%h exp=0", done_v); end
    checks++; if (step_count !== 32'd4) begin failures++; $display("FAIL cont_count got=%0d exp=4", step_count); end
  endtask

  task automatic test_start_with_stop();
    cfg_period = 32'd0; cfg_steps = 32'd1; mon_tvalid = 1'b1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy got=%b exp=0", busy); end
    checks++; if (step_count !== 32'd4) begin failures++; $display("FAIL startstop_count got=%0d exp=4", step_count); end
    tick();
    checks++; if ({trg_flag, busy, done} !== 3'b000) begin failures++; $display("FAIL startstop_idle got=%b exp=000", {trg_flag, busy, done}); end
    mon_tvalid = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    clear_v();
    cfg_period = 32'd2; cfg_steps = 32'd2; mon_tvalid = 1'b1; start = 1'b1;
    sample(0);
    for (int c = 1; c < 13; c++) begin
      tick();
      start = (c >= 4 && c <= 6);
      if (c == 2) begin
        cfg_period = 32'd0;
        cfg_steps  = 32'd5;
      end
      sample(c);
    end
    start = 1'b0;
    checks++; if (trg_v !== 32'h0000_0110) begin failures++; $display("FAIL ignored_trg got=%h exp=%h", trg_v, 32'h0000_0110); end
    checks++; if (done_v !== 32'h0000_0200) begin failures++; $display("FAIL ignored_done got=%h exp=%h", done_v, 32'h0000_0200); end
    checks++; if (busy_v !== 32'h0000_01FE) begin failures++; $display("FAIL ignored_busy got=%h exp=%h", busy_v, 32'h0000_01FE); end
    checks++; if (step_count !== 32'd2) begin failures++; $display("FAIL ignored_count got=%0d exp=2", step_count); end
  endtask

  task automatic test_reset_mid_run();
    clear_v();
    cfg_period = 32'd5; cfg_steps = 32'd10; mon_tvalid = 1'b1; start = 1'b1;
    sample(0);
    for (int c = 1; c < 16; c++) begin
      tick();
      start = 1'b0;
      mon_tvalid = (c <= 7) || (c == 15);
      areset = (c == 15);
      sample(c);
    end
    checks++; if (trg_v !== 32'h0000_C080) begin failures++; $display("FAIL midrst_trg got=%h exp=%h", trg_v, 32'h0000_C080); end
    checks++; if (step_count !== 32'd1) begin failures++; $display("FAIL midrst_precount got=%0d exp=1", step_count); end
    tick();
    checks++; if ({trg_flag, busy, done} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {trg_flag, busy, done}); end
    checks++; if (step_count !== 32'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", step_count); end
    areset = 1'b0; mon_tvalid = 1'b0;
    tick();
    clear_v();
    cfg_period = 32'd5; cfg_steps = 32'd2; mon_tvalid = 1'b1; start = 1'b1;
    sample(0);
    for (int c = 1; c < 17; c++) begin
      tick();
      start = 1'b0;
      sample(c);
    end
    mon_tvalid = 1'b0;
    checks++; if (trg_v !== 32'h0000_4080) begin failures++; $display("FAIL fresh_trg got=%h exp=%h", trg_v, 32'h0000_4080); end
    checks++; if (done_v !== 32'h0000_8000) begin failures++; $display("FAIL fresh_done got=%h exp=%h", done_v, 32'h0000_8000); end
    checks++; if (busy_v !== 32'h0000_7FFE) begin failures++; $display("FAIL fresh_busy got=%h exp=%h", busy_v, 32'h0000_7FFE); end
    checks++; if (step_count !== 32'd2) begin failures++; $display("FAIL fresh_count got=%0d exp=2", step_count); end
  endtask

  task automatic test_wrap();
    int n;
    int hit;
    n = 0;
    hit = -1;
    w_period = 4'd0; w_steps = 4'd0; w_tvalid = 1'b1; w_start = 1'b1;
    for (int c = 0; c < 100 && hit < 0; c++) begin
      if (c > 0) begin
        tick();
        w_start = 1'b0;
      end
      if (w_trg && w_tvalid) begin
        n++;
        if (n == 17) begin
          checks++; if (w_count !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", w_count); end
        end
        if (n == 20) begin
          w_stop = 1'b1;
          hit = c;
        end
      end
    end
    tick();
    w_stop = 1'b0; w_tvalid = 1'b0;
    checks++; if (hit !== 40) begin failures++; $display("FAIL wrap_cycle got=%0d exp=40", hit); end
    checks++; if (w_count !== 4'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", w_count); end
    checks++; if ({w_busy, w_done} !== 2'b00) begin failures++; $display("FAIL wrap_idle got=%b exp=00", {w_busy, w_done}); end
  endtask

  task automatic test_max_steps();
    int done_at;
    done_at = -1;
    w_period = 4'd0; w_steps = 4'hF; w_tvalid = 1'b1; w_start = 1'b1;
    for (int c = 1; c < 60 && done_at < 0; c++) begin
      tick();
      w_start = 1'b0;
      if (w_done) done_at = c;
    end
    checks++; if (done_at !== 31) begin failures++; $display("FAIL maxn_done_cycle got=%0d exp=31", done_at); end
    checks++; if (w_count !== 4'hF) begin failures++; $display("FAIL maxn_count got=%0d exp=15", w_count); end
    checks++; if (w_busy !== 1'b0) begin failures++; $display("FAIL maxn_busy got=%b exp=0", w_busy); end
    w_tvalid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_normal();
    test_stall();
    test_continuous_stop();
    test_start_with_stop();
    test_ignored_inputs();
    test_reset_mid_run();
    test_wrap();
    test_max_steps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_step_scheduler.md
# axis_step_scheduler

Sequences the trigger input of the AXI4-Stream single-beat gate (`axis_stepper`): emits `trg_flag` so that exactly one beat passes per step, with a programmable idle delay between steps and a programmable number of steps per run. It sits beside the gate in the acquisition path. It is configured from the usual cfg/sts register block, and it monitors the gate's upstream `tvalid` to detect each accepted beat.

## Interface
- `CNTR_WIDTH`, 32, width of the period, step-count and status counters.

- `aclk`  in  1  system clock; all logic is on its rising edge.
- `areset`  in  1  synchronous reset, active-high.
- `cfg_period`  in  CNTR_WIDTH  inter-step delay P in cycles; latched on accepted start.
- `cfg_steps`  in  CNTR_WIDTH  steps per run N; latched on accepted start; 0 means continuous.
- `start`  in  1  level sampled each cycle; acts only in IDLE.
- `stop`  in  1  abort request; acts in any non-IDLE state.
- `mon_tvalid`  in  1  gate upstream `s_axis_tvalid`. A beat transfers when `trg_flag & mon_tvalid`.
- `trg_flag`  out  1  to gate `trg_flag`; high only in ARMED.
- `busy`  out  1  high when state is not IDLE.
- `done`  out  1  one-cycle pulse on natural completion of a run.
- `step_count`  out  CNTR_WIDTH  beats transferred in the current or last run.

## Operation
- States: IDLE, DELAY, ARMED.
- **IDLE**
  - If `start & ~stop`: latch P and N, clear `step_count`, load delay counter with P, go to DELAY.
  - If `start & stop` in the same cycle: stop wins and the block stays in IDLE.
- **DELAY**
  - If the counter equals 0, go to ARMED. Otherwise decrement the counter.
  - DELAY therefore lasts P+1 cycles. P=0 gives one DELAY cycle.
- **ARMED**
  - `trg_flag` = 1. The block waits indefinitely for `mon_tvalid`.
  - On a transfer, `step_count` increments.
  - If N≠0 and the new count equals N: go to IDLE and pulse `done` in the next cycle.
  - Otherwise reload the counter with P and go to DELAY.
- **stop** in DELAY or ARMED: go to IDLE on the next edge, `trg_flag` drops, no `done` pulse.
  - If stop coincides with a transfer in ARMED, the beat counts: `step_count` increments and nothing else happens.
- **Ignored inputs:** `start` while busy is ignored. Config changes mid-run have no effect until the next start.
- **Continuous mode (N=0):** `step_count` wraps modulo 2^CNTR_WIDTH and the run never completes on its own.
- **Counter widths:** the delay counter and comparisons are unsigned CNTR_WIDTH. N = 2^CNTR_WIDTH−1 is legal.
- **Reset:** returns state to IDLE from any state, including mid-beat.
  - Reset values: `trg_flag` 0, `busy` 0, `done` 0, `step_count` 0, delay counter 0, latched P/N 0.

## Timing
- `trg_flag`, `busy`, `done` and `step_count` are registered; `trg_flag` is equivalent to registered state == ARMED.
- Start sampled in cycle 0: `busy` is high from cycle 1 and `trg_flag` is first high in cycle P+2.
- After a transfer in cycle t, `trg_flag` is low in cycle t+1, and next high in cycle t+P+2 for a non-final step.
- Final transfer in cycle t: `done` = 1 and `busy` = 0 in cycle t+1, and `step_count` = N from cycle t+1.
- Maximum rate: one beat per 2 cycles (P=0, `mon_tvalid` held high).
- Exactly one beat per ARMED interval, because `trg_flag` never stays high after a transfer edge.
- `stop` sampled in cycle t: `busy` = 0 and `trg_flag` = 0 in cycle t+1.

## Test plan
- **Normal run:** P=3, N=2, `mon_tvalid`=1, start in cycle 0.
  - `trg_flag` is high in cycles 5 and 10 only.
  - `done` pulses in cycle 11, `busy` is high in cycles 1–10, and `step_count` = 2.
- **Stalled source:** P=0, N=3, `mon_tvalid` low for cycles 0–9 and then held high.
  - `trg_flag` is high in cycles 2–10.
  - Transfers occur in cycles 10, 12 and 14, and `done` pulses in cycle 15.
- **Continuous + stop:** P=1, N=0, `mon_tvalid`=1, stop asserted during the 4th ARMED cycle.
  - `step_count` = 4, no `done` pulse, and `busy` is low the cycle after stop.
- **Edge-case inputs:** start with stop in the same cycle → stays IDLE. Start pulsed again mid-run → ignored. `cfg_period` changed mid-run → spacing unchanged.
- **Reset mid-run:** `areset` asserted during ARMED, P=5, N=10.
  - The next cycle shows all outputs at 0.
  - A new start behaves exactly like a fresh run.
- **Wrap:** CNTR_WIDTH=4, N=0, P=0, 20 transfers → `step_count` reads 4 (20 mod 16).
